// File: rtl/fifo_flow_controller.sv
// Handshake/sequencing controller for the parallel-write / parallel-read circular FIFO datapath.
// Optional watermark outputs are enabled with `define FIFO_FLOW_CTRL_WATERMARK_EN.
module fifo_flow_controller #(
    parameter int unsigned NUM_REG   = 4,
    parameter int unsigned NUMP1     = 5,
    parameter int unsigned PAR_WRITE = 1,
    parameter int unsigned PAR_READ  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    input  logic                        flush,
    output logic                        init_cnt,
    output logic                        inc_wptr,
    output logic                        inc_rptr,
    output logic                        reg_wen,
    output logic [$clog2(NUM_REG):0]    occupancy,
`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
    input  logic [$clog2(NUM_REG):0]    hi_mark,
    input  logic [$clog2(NUM_REG):0]    lo_mark,
    output logic                        almost_full,
    output logic                        almost_empty,
`endif
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned CW = $clog2(NUM_REG) + 1;
    localparam logic [CW:0] NR_W = (CW+1)'(NUM_REG);
    localparam logic [CW:0] PW_W = (CW+1)'(PAR_WRITE);
    localparam logic [CW:0] PR_W = (CW+1)'(PAR_READ);

    if (PAR_WRITE < 1 || PAR_WRITE > NUM_REG || PAR_READ < 1 || PAR_READ > NUM_REG ||
        NUMP1 != NUM_REG + 1) begin : g_bad_params
        $error("fifo_flow_controller: illegal NUM_REG/NUMP1/PAR_WRITE/PAR_READ combination");
    end

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            armed;
    logic            wa;
    logic            ra;
    logic            can_write;
    logic            can_read;
    logic [CW:0]     occ_ext;
    logic [CW:0]     occ_sum;
    logic [CW-1:0]   occ_nxt;

    // Readiness is a pure decode of the occupancy register, never of the handshake inputs
    assign occ_ext   = {1'b0, occupancy};
    assign can_write = (occ_ext + PW_W) <= NR_W;
    assign can_read  = occ_ext >= PR_W;
    assign occ_nxt   = CW'(occ_sum);

    assign full     = ~can_write;
    assign empty    = (occupancy == '0);
    assign inc_wptr = wa;
    assign inc_rptr = ra;
    assign reg_wen  = wa;

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        wa        = 1'b0;
        ra        = 1'b0;
        init_cnt  = 1'b0;
        occ_sum   = occ_ext;
        case (state)
            // armed keeps init_cnt low while reset is still being released
            ST_INIT: begin
                init_cnt = armed;
                if (armed) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_ready = can_write;
                rd_valid = can_read;
                if (flush) begin
                    state_nxt = ST_FLUSH;
                end else begin
                    wa = wr_valid & can_write;
                    ra = rd_ready & can_read;
                end
                occ_sum = occ_ext + (wa ? PW_W : '0) - (ra ? PR_W : '0);
            end
            ST_FLUSH: begin
                init_cnt  = 1'b1;
                occ_sum   = '0;
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT;
            armed     <= 1'b0;
            occupancy <= '0;
        end else begin
            state     <= state_nxt;
            armed     <= 1'b1;
            occupancy <= occ_nxt;
        end
    end

`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
    // Watermarks track the value occupancy takes on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (state == ST_FLUSH) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= occ_nxt >= hi_mark;
            almost_empty <= occ_nxt <= lo_mark;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flow_controller.sv
// Self-checking bench for fifo_flow_controller: directed scenarios plus random traffic
// against a word-count reference model.
module tb_fifo_flow_controller;

    localparam int NUM_REG   = 4;
    localparam int NUMP1     = 5;
    localparam int PAR_WRITE = 1;
    localparam int PAR_READ  = 2;
    localparam int CW        = $clog2(NUM_REG) + 1;
    localparam int HI_MARK   = 3;
    localparam int LO_MARK   = 1;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic          rd_ready;
    logic          rd_valid;
    logic          flush;
    logic          init_cnt;
    logic          inc_wptr;
    logic          inc_rptr;
    logic          reg_wen;
    logic [CW-1:0] occupancy;
    logic          full;
    logic          empty;
`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
    logic [CW-1:0] hi_mark;
    logic [CW-1:0] lo_mark;
    logic          almost_full;
    logic          almost_empty;
`endif

    fifo_flow_controller #(
        .NUM_REG  (NUM_REG),
        .NUMP1    (NUMP1),
        .PAR_WRITE(PAR_WRITE),
        .PAR_READ (PAR_READ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .flush       (flush),
        .init_cnt    (init_cnt),
        .inc_wptr    (inc_wptr),
        .inc_rptr    (inc_rptr),
        .reg_wen     (reg_wen),
        .occupancy   (occupancy),
`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
        .hi_mark     (hi_mark),
        .lo_mark     (lo_mark),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
`endif
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_wen   = 0;

    // Reference model: stored word count plus "a flush cycle is pending"
    int m_occ   = 0;
    bit m_fl    = 1'b0;
    bit m_af    = 1'b0;
    bit m_ae    = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_wr_ready"}, 32'(wr_ready), 0);
        check_eq({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check_eq({tag, "_occ"},      32'(occupancy), 0);
        check_eq({tag, "_full"},     32'(full), 0);
        check_eq({tag, "_empty"},    32'(empty), 1);
        check_eq({tag, "_init"},     32'(init_cnt), 0);
        check_eq({tag, "_inc"},      32'({inc_wptr, inc_rptr, reg_wen}), 0);
`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
        check_eq({tag, "_af"},       32'(almost_full), 0);
        check_eq({tag, "_ae"},       32'(almost_empty), 1);
`endif
    endtask

    // Called at a negedge right after reset release; waits (bounded) for the init pulse
    task automatic do_init();
        int waited;
        waited   = 0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        while (init_cnt !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check_eq("init_pulse",    32'(init_cnt), 1);
        check_eq("init_wr_ready", 32'(wr_ready), 0);
        check_eq("init_rd_valid", 32'(rd_valid), 0);
        check_eq("init_inc",      32'({inc_wptr, inc_rptr}), 0);
        @(posedge clk);
        #1;
        m_occ = 0;
        m_fl  = 1'b0;
        m_af  = 1'b0;
        m_ae  = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs at the negedge, advance the model
    task automatic cycle(input bit wv, input bit rv, input bit fl);
        bit exp_wr;
        bit exp_rd;
        bit exp_wa;
        bit exp_ra;
        bit was_fl;
        wr_valid = wv;
        rd_ready = rv;
        flush    = fl;
        @(negedge clk);
        exp_wr = !m_fl && (NUM_REG - m_occ >= PAR_WRITE);
        exp_rd = !m_fl && (m_occ >= PAR_READ);
        exp_wa = !m_fl && !fl && wv && exp_wr;
        exp_ra = !m_fl && !fl && rv && exp_rd;
        check_eq("wr_ready",  32'(wr_ready),  32'(exp_wr));
        check_eq("rd_valid",  32'(rd_valid),  32'(exp_rd));
        check_eq("init_cnt",  32'(init_cnt),  32'(m_fl));
        check_eq("inc_wptr",  32'(inc_wptr),  32'(exp_wa));
        check_eq("reg_wen",   32'(reg_wen),   32'(exp_wa));
        check_eq("inc_rptr",  32'(inc_rptr),  32'(exp_ra));
        check_eq("occupancy", 32'(occupancy), 32'(m_occ));
        check_eq("full",      32'(full),      32'(m_occ > NUM_REG - PAR_WRITE));
        check_eq("empty",     32'(empty),     32'(m_occ == 0));
`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
        check_eq("almost_full",  32'(almost_full),  32'(m_af));
        check_eq("almost_empty", 32'(almost_empty), 32'(m_ae));
`endif
        if (reg_wen === 1'b1) n_wen++;
        was_fl = m_fl;
        if (m_fl) begin
            m_occ = 0;
            m_fl  = 1'b0;
        end else if (fl) begin
            m_fl  = 1'b1;
        end else begin
            m_occ = m_occ + (exp_wa ? PAR_WRITE : 0) - (exp_ra ? PAR_READ : 0);
        end
        if (was_fl) begin
            m_af = 1'b0;
            m_ae = 1'b1;
        end else begin
            m_af = (m_occ >= HI_MARK);
            m_ae = (m_occ <= LO_MARK);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
        hi_mark  = CW'(HI_MARK);
        lo_mark  = CW'(LO_MARK);
`endif
        repeat (3) @(posedge clk);
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;
        do_init();

        // Fill past capacity: only NUM_REG/PAR_WRITE writes accepted
        n_wen = 0;
        repeat (6) cycle(1'b1, 1'b0, 1'b0);
        check_eq("fill_wen_pulses", 32'(n_wen), 32'(NUM_REG / PAR_WRITE));
        check_eq("fill_occ",        32'(occupancy), 32'(NUM_REG));

        // Drain: two PAR_READ reads, then rd_valid holds low
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        check_eq("drain_occ", 32'(occupancy), 0);

        // Occupancy 3, simultaneous write and read
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("simul_occ", 32'(occupancy), 2);

        // Occupancy 3, flush with a write offered
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("flush_occ",      32'(occupancy), 0);
        check_eq("flush_wr_ready", 32'(wr_ready), 1);

        // flush held high alternates RUN(suppressed) and FLUSH
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // Occupancy 2, asynchronous reset in the middle of a cycle
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_occ", 32'(occupancy), 2);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b1;
        do_init();
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
`ifdef FIFO_FLOW_CTRL_WATERMARK_EN
        check_eq("wm_af_after3", 32'(almost_full), 1);
`endif
        check_eq("post_rst_occ", 32'(occupancy), 3);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
